// File: rtl/shift_ring_counter_n.sv
// shift_ring_counter_n: N-bit ring/Johnson shift counter with load, self-correction and wrap pulse
module shift_ring_counter_n #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             error
);
   logic [WIDTH-1:0] q_q, q_d, seed_in, seed_cur, shifted;
   logic             mode_q, wrap_q, wrap_d, error_q, error_d, legal, steady;
   always_comb begin
      seed_in  = mode ? '0 : WIDTH'(1);
      seed_cur = mode_q ? '0 : WIDTH'(1);
      legal    = mode_q ? ($countones(q_q[WIDTH-2:0] ^ q_q[WIDTH-1:1]) <= 1)
                        : ($countones(q_q) == 1);
      shifted  = dir ? {q_q[0] ^ mode_q, q_q[WIDTH-1:1]}
                     : {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ mode_q};
      steady   = !reset && !load && (mode == mode_q) && enable;
      q_d      = reset ? seed_in : load ? load_value : (mode != mode_q) ? seed_in :
                 !enable ? q_q : !legal ? seed_cur : shifted;
      error_d  = steady && !legal;
      wrap_d   = steady && legal && (shifted == seed_cur);
   end
   always_ff @(posedge clock) begin
      mode_q  <= mode;
      q_q     <= q_d;
      wrap_q  <= reset ? 1'b0 : wrap_d;
      error_q <= reset ? 1'b0 : error_d;
   end
   assign q     = q_q;
   assign wrap  = wrap_q;
   assign error = error_q;
endmodule

// File: tb/tb_shift_ring_counter_n.sv
// tb_shift_ring_counter_n: directed vectors with a queue scoreboard checked by an independent monitor
module tb_shift_ring_counter_n;
   logic       clock = 0, reset = 0, enable = 0, mode = 0, dir = 0, load = 0;
   logic [3:0] load_value = '0;
   logic [3:0] q;
   logic       wrap, error;
   typedef struct {logic [3:0] q; logic w; logic e; int id;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, n = 0;
   shift_ring_counter_n #(.WIDTH(4)) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
      .load(load), .load_value(load_value), .q(q), .wrap(wrap), .error(error)
   );
   always #5 clock = ~clock;
   task automatic step(input logic r, l, e, m, d, input logic [3:0] lv,
                       input logic [3:0] eq, input logic ew, ee);
      exp_t x;
      @(negedge clock);
      reset = r; load = l; enable = e; mode = m; dir = d; load_value = lv;
      x.q = eq; x.w = ew; x.e = ee; x.id = n++;
      sb.push_back(x);
   endtask
   initial forever begin
      exp_t x;
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         checks++;
         if (q !== x.q || wrap !== x.w || error !== x.e) begin
            errors++;
            $display("FAIL step%0d: got q=%b wrap=%b error=%b, want q=%b wrap=%b error=%b",
                     x.id, q, wrap, error, x.q, x.w, x.e);
         end
      end
   end
   initial begin
      // ring left: r l e m d lv -> q w e
      step(1,0,1,0,0,4'h0, 4'b0001,0,0);
      step(0,0,1,0,0,4'h0, 4'b0010,0,0);
      step(0,0,1,0,0,4'h0, 4'b0100,0,0);
      step(0,0,1,0,0,4'h0, 4'b1000,0,0);
      step(0,0,1,0,0,4'h0, 4'b0001,1,0);
      step(0,0,1,0,0,4'h0, 4'b0010,0,0);
      // Johnson left
      step(1,0,0,1,0,4'h0, 4'b0000,0,0);
      step(0,0,1,1,0,4'h0, 4'b0001,0,0);
      step(0,0,1,1,0,4'h0, 4'b0011,0,0);
      step(0,0,1,1,0,4'h0, 4'b0111,0,0);
      step(0,0,1,1,0,4'h0, 4'b1111,0,0);
      step(0,0,1,1,0,4'h0, 4'b1110,0,0);
      step(0,0,1,1,0,4'h0, 4'b1100,0,0);
      step(0,0,1,1,0,4'h0, 4'b1000,0,0);
      step(0,0,1,1,0,4'h0, 4'b0000,1,0);
      // Johnson right
      step(1,0,1,1,1,4'h0, 4'b0000,0,0);
      step(0,0,1,1,1,4'h0, 4'b1000,0,0);
      step(0,0,1,1,1,4'h0, 4'b1100,0,0);
      step(0,0,1,1,1,4'h0, 4'b1110,0,0);
      step(0,0,1,1,1,4'h0, 4'b1111,0,0);
      step(0,0,1,1,1,4'h0, 4'b0111,0,0);
      step(0,0,1,1,1,4'h0, 4'b0011,0,0);
      step(0,0,1,1,1,4'h0, 4'b0001,0,0);
      step(0,0,1,1,1,4'h0, 4'b0000,1,0);
      // ring correction: illegal held silently while disabled
      step(1,0,0,0,0,4'h0, 4'b0001,0,0);
      step(0,1,0,0,0,4'b0101, 4'b0101,0,0);
      step(0,0,0,0,0,4'h0, 4'b0101,0,0);
      step(0,0,1,0,0,4'h0, 4'b0001,0,1);
      step(0,0,1,0,0,4'h0, 4'b0010,0,0);
      // Johnson correction, load also switches mode
      step(0,1,1,1,0,4'b0110, 4'b0110,0,0);
      step(0,0,1,1,0,4'h0, 4'b0000,0,1);
      // ring correction of two-hot value
      step(0,1,1,0,0,4'b1100, 4'b1100,0,0);
      step(0,0,1,0,0,4'h0, 4'b0001,0,1);
      // direction reversal at 0100
      step(0,0,1,0,0,4'h0, 4'b0010,0,0);
      step(0,0,1,0,0,4'h0, 4'b0100,0,0);
      step(0,0,1,0,1,4'h0, 4'b0010,0,0);
      step(0,0,1,0,1,4'h0, 4'b0001,1,0);
      // load beats enable
      step(0,0,1,0,0,4'h0, 4'b0010,0,0);
      step(0,0,1,0,0,4'h0, 4'b0100,0,0);
      step(0,1,1,0,0,4'b1000, 4'b1000,0,0);
      step(0,0,1,0,0,4'h0, 4'b0001,1,0);
      // mode change with enable low, then back to Johnson
      step(0,0,0,1,0,4'h0, 4'b0000,0,0);
      step(0,0,1,1,0,4'h0, 4'b0001,0,0);
      step(0,0,1,1,0,4'h0, 4'b0011,0,0);
      step(0,0,1,1,0,4'h0, 4'b0111,0,0);
      step(0,0,0,0,0,4'h0, 4'b0001,0,0);
      step(0,0,1,1,0,4'h0, 4'b0000,0,0);
      step(0,0,1,1,0,4'h0, 4'b0001,0,0);
      step(0,0,1,1,0,4'h0, 4'b0011,0,0);
      step(0,0,1,1,0,4'h0, 4'b0111,0,0);
      // reset beats load, then plain hold
      step(1,1,1,1,0,4'b1010, 4'b0000,0,0);
      step(0,0,0,1,0,4'h0, 4'b0000,0,0);
      step(0,0,0,1,1,4'h0, 4'b0000,0,0);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
      #2;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
